perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CNT hardware event counters for the LC-3b pipeline, CNT_WIDTH bits each, memory-mapped in a 32-byte window at BASE_ADDR. Each counter has a wrap or saturate mode and a sticky overflow flag. Software gets a global freeze, per-counter and global clear, and a coherent two-word read of wide counters through a hi-half shadow. The bank sits beside the data-memory port: the datapath feeds event strobes and steers matching loads and stores to this block.

---
 rtl/perf_pkg.sv | 15 +
 rtl/perf_counter_cell.sv | 40 ++++
 rtl/perf_counter_bank.sv | 164 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants and bus FSM state type for the perf counter bank
// Contents: register offsets inside the 32-byte window, bus FSM enum, hi-half helper.
package perf_pkg;

  localparam logic [4:0] PERF_CTRL_OFS   = 5'h1C;
  localparam logic [4:0] PERF_STATUS_OFS = 5'h1E;

  typedef enum logic {PB_IDLE, PB_RESP} perf_bus_state_t;

  // Upper 16 bits of a counter that has been zero-extended to 32 bits.
  function automatic logic [15:0] hi_half(input logic [31:0] v);
    return v[31:16];
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - single event counter with wrap/saturate and overflow pulse
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         increment request (already gated by freeze)
//   clr         synchronous clear; wins over inc
//   count       current counter value
//   ovf_pulse   high in a cycle where an increment hits the all-ones value
module perf_counter_cell #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf_pulse
);

  logic at_max;

  assign at_max    = &count;
  // A clear drops the increment, so no overflow can be reported alongside it.
  assign ovf_pulse = inc & ~clr & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (!at_max) begin
        count <= count + WIDTH'(1);
      end else if (SATURATE == 1'b0) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - memory-mapped bank of event counters with freeze, clear and coherent hi-half reads
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   inc_vec        per-counter event strobes
//   mem_address    byte address (bit 0 ignored)
//   mem_read/write request strobes, held until mem_resp
//   mem_wdata      write data (always a full word)
//   mem_sel        combinational window hit
//   mem_resp       one-cycle response pulse
//   mem_rdata      registered read data, held between responses
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int          NUM_CNT   = 4,
  parameter int          CNT_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR = 16'hFFE0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] inc_vec,
  input  logic [15:0]        mem_address,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [15:0]        mem_wdata,
  output logic               mem_sel,
  output logic               mem_resp,
  output logic [15:0]        mem_rdata
);

  perf_bus_state_t state;

  logic               freeze;
  logic [NUM_CNT-1:0] ovf;
  logic [15:0]        shadow_hi;
  logic [2:0]         shadow_idx;

  logic [4:0]         ofs;
  logic [2:0]         idx;
  logic               is_hi;
  logic               is_cnt;
  logic               access;
  logic               do_read;
  logic               do_write;
  logic               clear_all;

  logic [NUM_CNT-1:0] inc_eff;
  logic [NUM_CNT-1:0] clr_vec;
  logic [NUM_CNT-1:0] ovf_pulse;
  logic [NUM_CNT-1:0] w1c;
  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [31:0]        cnt_ext [NUM_CNT];

  logic [15:0]        lo_sel;
  logic [15:0]        hi_live;
  logic [15:0]        rd_val;

  logic               unused_bits;

  assign unused_bits = ^{mem_address[0], mem_wdata};

  assign mem_sel = (mem_address[15:5] == BASE_ADDR[15:5]);
  assign ofs     = {mem_address[4:1], 1'b0};
  assign idx     = ofs[4:2];
  assign is_hi   = ofs[1];
  // Offsets 0x1C/0x1E decode to idx 7, which is never a counter since NUM_CNT <= 7.
  assign is_cnt  = (32'(idx) < NUM_CNT);

  assign access    = (state == PB_IDLE) && mem_sel && (mem_read || mem_write);
  assign do_read   = access && mem_read;
  assign do_write  = access && !mem_read && mem_write;
  assign clear_all = do_write && (ofs == PERF_CTRL_OFS) && mem_wdata[1];

  assign inc_eff = inc_vec & {NUM_CNT{~freeze}};
  assign w1c     = (do_write && (ofs == PERF_STATUS_OFS)) ? mem_wdata[NUM_CNT-1:0] : '0;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      clr_vec[i] = clear_all || (do_write && is_cnt && (32'(idx) == i));
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
    perf_counter_cell #(
      .WIDTH    (CNT_WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_eff[g]),
      .clr       (clr_vec[g]),
      .count     (cnt[g]),
      .ovf_pulse (ovf_pulse[g])
    );
    assign cnt_ext[g] = 32'(cnt[g]);
  end

  always_comb begin
    lo_sel  = '0;
    hi_live = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (32'(idx) == i) begin
        lo_sel  = cnt_ext[i][15:0];
        hi_live = hi_half(cnt_ext[i]);
      end
    end
    if (is_cnt) begin
      // The hi half comes from the shadow only when it belongs to this counter.
      if (is_hi) begin
        rd_val = (shadow_idx == idx) ? shadow_hi : hi_live;
      end else begin
        rd_val = lo_sel;
      end
    end else if (ofs == PERF_CTRL_OFS) begin
      rd_val = {15'b0, freeze};
    end else if (ofs == PERF_STATUS_OFS) begin
      rd_val = 16'(ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PB_IDLE;
      mem_resp   <= 1'b0;
      mem_rdata  <= '0;
      freeze     <= 1'b0;
      ovf        <= '0;
      shadow_hi  <= '0;
      shadow_idx <= '0;
    end else begin
      // A fresh overflow beats a same-cycle W1C of that bit.
      ovf <= (ovf & ~w1c) | ovf_pulse;
      case (state)
        PB_IDLE: begin
          mem_resp <= 1'b0;
          if (access) begin
            state    <= PB_RESP;
            mem_resp <= 1'b1;
            if (do_read) begin
              mem_rdata <= rd_val;
              if (is_cnt && !is_hi) begin
                shadow_hi  <= hi_live;
                shadow_idx <= idx;
              end
            end else if (ofs == PERF_CTRL_OFS) begin
              freeze <= mem_wdata[0];
            end
          end
        end
        PB_RESP: begin
          mem_resp <= 1'b0;
          state    <= PB_IDLE;
        end
        default: begin
          mem_resp <= 1'b0;
          state    <= PB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank (32-bit wrap, 16-bit wrap, 16-bit saturate)
module tb_perf_counter_bank;

  localparam logic [15:0] BASE = 16'hFFE0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  inc0 = '0, inc1 = '0, inc2 = '0;
  logic [15:0] addr = '0, wdata = '0;
  logic [2:0]  rd = '0, wr = '0;
  logic [2:0]  sel, resp;
  logic [15:0] rdata [3];

  typedef struct {
    int          tgt;
    bit          is_rd;
    logic [15:0] exp;
    logic [15:0] a;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(32), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .inc_vec(inc0), .mem_address(addr), .mem_read(rd[0]),
    .mem_write(wr[0]), .mem_wdata(wdata), .mem_sel(sel[0]), .mem_resp(resp[0]), .mem_rdata(rdata[0]));

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(16), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inc_vec(inc1), .mem_address(addr), .mem_read(rd[1]),
    .mem_write(wr[1]), .mem_wdata(wdata), .mem_sel(sel[1]), .mem_resp(resp[1]), .mem_rdata(rdata[1]));

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(16), .BASE_ADDR(BASE), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .inc_vec(inc2), .mem_address(addr), .mem_read(rd[2]),
    .mem_write(wr[2]), .mem_wdata(wdata), .mem_sel(sel[2]), .mem_resp(resp[2]), .mem_rdata(rdata[2]));

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      if (resp[t]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp tgt=%0d rdata=%h", t, rdata[t]);
        end else begin
          e = q.pop_front();
          if (e.tgt != t || (e.is_rd && rdata[t] !== e.exp)) begin
            errors++;
            $display("FAIL resp addr=%h got tgt=%0d rdata=%h expected tgt=%0d rdata=%h",
                     e.a, t, rdata[t], e.tgt, e.exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic bus(input int t, input logic [15:0] a, input bit w, input logic [15:0] d,
                     input logic [15:0] e);
    int  k;
    bit  seen;
    q.push_back('{t, !w, e, a});
    addr  = a;
    wdata = d;
    if (w) wr[t] = 1'b1;
    else   rd[t] = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      if (resp[t]) seen = 1'b1;
    end
    chk("latency", 16'(k), 16'd1);
    rd = '0;
    wr = '0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input int t, input logic [7:0] off, input logic [15:0] e);
    bus(t, 16'(BASE + off), 1'b0, 16'h0, e);
  endtask

  task automatic wr_reg(input int t, input logic [7:0] off, input logic [15:0] d);
    bus(t, 16'(BASE + off), 1'b1, d, 16'h0);
  endtask

  task automatic pulse_inc(input int t, input logic [3:0] v, input int n);
    case (t)
      0: inc0 = v;
      1: inc1 = v;
      default: inc2 = v;
    endcase
    repeat (n) @(negedge clk);
    case (t)
      0: inc0 = '0;
      1: inc1 = '0;
      default: inc2 = '0;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit resp_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      chk("reset_resp", 16'(resp[t]), 16'h0);
      chk("reset_rdata", rdata[t], 16'h0);
    end
    addr = 16'hFFFF; #1 chk("sel_top_of_window", 16'(sel), 16'h7);
    addr = 16'hFFDF; #1 chk("sel_below_window", 16'(sel), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic count and read.
    pulse_inc(0, 4'b0001, 10);
    rd_chk(0, 8'h00, 16'h000A);
    rd_chk(0, 8'h04, 16'h0000);
    rd_chk(0, 8'h02, 16'h0000);

    // Long run: 16-bit wrap, 16-bit saturate, and counter 2 of the 32-bit bank.
    fork
      pulse_inc(1, 4'b0010, 65537);
      pulse_inc(2, 4'b0001, 70000);
      pulse_inc(0, 4'b0100, 65534);
    join
    rd_chk(1, 8'h04, 16'h0001);
    rd_chk(1, 8'h1E, 16'h0002);
    wr_reg(1, 8'h1E, 16'h0002);
    rd_chk(1, 8'h1E, 16'h0000);
    rd_chk(2, 8'h00, 16'hFFFF);
    rd_chk(2, 8'h1E, 16'h0001);

    // Coherent two-word read across a lo-half rollover.
    rd_chk(0, 8'h08, 16'hFFFE);
    pulse_inc(0, 4'b0100, 3);
    rd_chk(0, 8'h0A, 16'h0000);
    rd_chk(0, 8'h08, 16'h0001);
    rd_chk(0, 8'h0A, 16'h0001);
    rd_chk(0, 8'h1E, 16'h0000);

    // Read samples the value before the same-edge increment.
    inc0 = 4'b0001;
    rd_chk(0, 8'h00, 16'h000A);
    inc0 = 4'b0000;
    rd_chk(0, 8'h00, 16'h000C);

    // Per-counter clear through the hi-half offset.
    wr_reg(0, 8'h0A, 16'hFFFF);
    rd_chk(0, 8'h08, 16'h0000);
    rd_chk(0, 8'h00, 16'h000C);

    // Freeze.
    wr_reg(0, 8'h1C, 16'h0001);
    rd_chk(0, 8'h1C, 16'h0001);
    pulse_inc(0, 4'hF, 5);
    rd_chk(0, 8'h00, 16'h000C);
    rd_chk(0, 8'h04, 16'h0000);
    wr_reg(0, 8'h1C, 16'h0000);
    pulse_inc(0, 4'hF, 2);
    rd_chk(0, 8'h04, 16'h0002);
    rd_chk(0, 8'h00, 16'h000E);

    // Clear-all beats a simultaneous increment.
    fork
      pulse_inc(0, 4'hF, 1);
      wr_reg(0, 8'h1C, 16'h0002);
    join
    rd_chk(0, 8'h00, 16'h0000);
    rd_chk(0, 8'h0C, 16'h0000);
    rd_chk(0, 8'h1C, 16'h0000);

    // Overflow beats same-cycle W1C; clear-all keeps overflow flags.
    fork
      pulse_inc(2, 4'b0001, 1);
      wr_reg(2, 8'h1E, 16'h0001);
    join
    rd_chk(2, 8'h1E, 16'h0001);
    wr_reg(2, 8'h1C, 16'h0002);
    rd_chk(2, 8'h00, 16'h0000);
    rd_chk(2, 8'h1E, 16'h0001);
    wr_reg(2, 8'h1E, 16'h0001);
    rd_chk(2, 8'h1E, 16'h0000);

    // Unmapped offset, odd address.
    pulse_inc(0, 4'b0001, 3);
    rd_chk(0, 8'h18, 16'h0000);
    wr_reg(0, 8'h18, 16'h1234);
    rd_chk(0, 8'h01, 16'h0003);

    // Outside the window: no select, no response.
    addr = 16'hFFC0;
    rd[0] = 1'b1;
    #1 chk("sel_outside", 16'(sel[0]), 16'h0);
    resp_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp != 3'b000) resp_seen = 1'b1;
    end
    chk("no_resp_outside", 16'(resp_seen), 16'h0);
    rd = '0;
    @(negedge clk);

    // Reset in the middle of a response.
    wr_reg(0, 8'h1C, 16'h0001);
    addr = BASE;
    rd[0] = 1'b1;
    @(posedge clk);
    #2 chk("resp_before_reset", 16'(resp[0]), 16'h1);
    rst_n = 1'b0;
    #1 chk("resp_async_reset", 16'(resp[0]), 16'h0);
    chk("rdata_async_reset", rdata[0], 16'h0);
    @(negedge clk);
    rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resp_after_reset", 16'(resp[0]), 16'h0);
    rd_chk(0, 8'h00, 16'h0000);
    rd_chk(0, 8'h1C, 16'h0000);

    repeat (3) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
